fir_out_decimator: RTL



---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_sync_fifo.sv | 55 +++++
 rtl/fir_out_decimator.sv | 101 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample width, sample type, ceil-log2 helper.
package fir_pkg;
    localparam int DATA_W = 11;

    typedef logic signed [DATA_W-1:0] sample_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/fir_sync_fifo.sv
// Registered sync FIFO with first-word fall-through head; full/empty derive from level.
// Latency: a push shows at rdata after the next edge. Backpressure: caller must gate push when full.
// Overflow handling is left to the caller.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic [clog2(DEPTH):0]   level,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;
endmodule

// File: rtl/fir_out_decimator.sv
// FIR output decimator: keeps one sample per DECIM group (or block-averages it with FIR_DECIM_AVG_EN) into a FIFO.
// Latency: kept sample visible on DOUT/VOUT one cycle after its VIN edge.
// Backpressure: RDY stalls the FIFO; pushes into a full FIFO without a pop are dropped and set sticky OVF.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int DECIM  = 4,
    parameter int PHASE  = 0,
    parameter int DEPTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [DATA_W-1:0]       DIN,
    input  logic                    VIN,
    output logic [DATA_W-1:0]       DOUT,
    output logic                    VOUT,
    input  logic                    RDY,
    input  logic                    CLR_OVF,
    output logic                    OVF,
    output logic [clog2(DEPTH):0]   LEVEL
);
    localparam int PH_W = (DECIM > 1) ? clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]   ph_q, ph_d;
    logic              ovf_q, ovf_d;
    logic              push_req, push_ok, pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] push_dat;

    always_comb begin
        ph_d = ph_q;
        if (VIN) ph_d = (ph_q == LAST) ? '0 : ph_q + PH_W'(1);
    end

`ifdef FIR_DECIM_AVG_EN
    localparam int ACC_W = DATA_W + 4;
    localparam int SH    = clog2(DECIM);

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, acc_shr;

    // Phase 0 restarts the sum so no explicit clear is needed between groups.
    always_comb begin
        acc_sum  = ((ph_q == '0) ? '0 : acc_q) + {{(ACC_W - DATA_W){DIN[DATA_W-1]}}, DIN};
        acc_d    = VIN ? acc_sum : acc_q;
        acc_shr  = acc_sum >>> SH;
        push_req = VIN && (ph_q == LAST);
        push_dat = acc_shr[DATA_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
`else
    localparam logic [PH_W-1:0] KEEP = PH_W'(PHASE);

    always_comb begin
        push_req = VIN && (ph_q == KEEP);
        push_dat = DIN;
    end
`endif

    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    always_comb begin
        pop     = RDY && !fifo_empty;
        push_ok = push_req && (!fifo_full || pop);
        ovf_d   = ovf_q;
        if (CLR_OVF) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ph_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            ovf_q <= ovf_d;
        end
    end

    fir_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_n),
        .push  (push_ok),
        .pop   (pop),
        .wdata (push_dat),
        .rdata (DOUT),
        .level (LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign VOUT = !fifo_empty;
    assign OVF  = ovf_q;
endmodule
